// File: rtl/sec_an_decode_ctrl.sv
// Two-requester round-robin AN-code decoder with single-error (+/-2^i) correction.
// Define SEC_CTRL_ERRCNT_EN to add saturating cnt_corr / cnt_uncorr outputs.
module sec_an_decode_ctrl #(
  parameter logic [11:0] A = 12'd3349
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [23:0] req0_w,
  input  logic        req1_valid,
  input  logic [23:0] req1_w,
  output logic        req0_ready,
  output logic        req1_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] out_n,
  output logic        out_id,
  output logic        out_corr,
  output logic        out_uncorr
`ifdef SEC_CTRL_ERRCNT_EN
  ,
  output logic [15:0] cnt_corr,
  output logic [15:0] cnt_uncorr
`endif
);

  typedef enum logic [2:0] {IDLE, DIV1, CHK, DIV2, OUT} state_t;

  state_t      state;
  logic        ptr;
  logic        id_r;
  logic [24:0] w_r;
  logic [24:0] dq;
  logic [11:0] rem;
  logic [4:0]  cnt;

  logic        grant0;
  logic        grant1;
  logic [12:0] trial;
  logic        step_ge;
  logic [11:0] rem_next;
  logic [24:0] dq_next;
  logic [24:0] delta;
  logic [11:0] pos_res;

  function automatic logic [11:0] pow2_mod(input int i);
    return 12'((32'd1 << i) % 32'(A));
  endfunction

  assign grant0     = req0_valid && (!ptr || !req1_valid);
  assign grant1     = req1_valid && (ptr || !req0_valid);
  assign req0_ready = (state == IDLE) && !rst && grant0;
  assign req1_ready = (state == IDLE) && !rst && grant1;

  // One restoring-division step: dq shifts dividend bits out and quotient bits in.
  assign trial    = {rem, dq[24]};
  assign step_ge  = trial >= {1'b0, A};
  assign rem_next = step_ge ? 12'(trial - {1'b0, A}) : trial[11:0];
  assign dq_next  = {dq[23:0], step_ge};

  // Syndrome lookup; the lowest matching i wins, +2^i preferred over -2^i.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path infers a latch.
    delta   = '0;
    pos_res = '0;
    for (int i = 23; i >= 0; i--) begin
      pos_res = pow2_mod(i);
      if (rem == A - pos_res) delta = 25'd0 - (25'd1 << i);
      if (rem == pos_res)     delta = 25'd1 << i;
    end
  end

  // NOTE: registered state uses non-blocking assignments only, so every read sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= 1'b0;
      id_r       <= 1'b0;
      w_r        <= '0;
      dq         <= '0;
      rem        <= '0;
      cnt        <= '0;
      out_valid  <= 1'b0;
      out_n      <= '0;
      out_id     <= 1'b0;
      out_corr   <= 1'b0;
      out_uncorr <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            id_r  <= grant1;
            w_r   <= {1'b0, grant1 ? req1_w : req0_w};
            dq    <= {1'b0, grant1 ? req1_w : req0_w};
            rem   <= '0;
            cnt   <= '0;
            ptr   <= !grant1;
            state <= DIV1;
          end
        end
        DIV1, DIV2: begin
          dq  <= dq_next;
          rem <= rem_next;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd24) begin
            if (state == DIV1) begin
              state <= CHK;
            end else begin
              state      <= OUT;
              out_valid  <= 1'b1;
              out_n      <= dq_next[11:0];
              out_id     <= id_r;
              out_corr   <= 1'b1;
              out_uncorr <= 1'b0;
            end
          end
        end
        CHK: begin
          if (delta == '0) begin
            state      <= OUT;
            out_valid  <= 1'b1;
            out_n      <= dq[11:0];
            out_id     <= id_r;
            out_corr   <= 1'b0;
            out_uncorr <= (rem != '0);
          end else begin
            dq    <= w_r - delta;
            rem   <= '0;
            cnt   <= '0;
            state <= DIV2;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SEC_CTRL_ERRCNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_corr   <= '0;
      cnt_uncorr <= '0;
    end else if (out_valid && out_ready) begin
      if (out_corr && cnt_corr != 16'hFFFF)     cnt_corr   <= cnt_corr + 16'd1;
      if (out_uncorr && cnt_uncorr != 16'hFFFF) cnt_uncorr <= cnt_uncorr + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sec_an_decode_ctrl.sv
// Scoreboard bench for sec_an_decode_ctrl: directed cases, round-robin, backpressure,
// randomized codewords and reset-abort, checked against an arithmetic reference model.
`timescale 1ns/1ps
module tb_sec_an_decode_ctrl;

  localparam logic [11:0] A       = 12'd3349;
  localparam int          AI      = 3349;
  localparam int          TIMEOUT = 2000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [23:0] req0_w = '0, req1_w = '0;
  logic        req0_ready, req1_ready;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [11:0] out_n;
  logic        out_id, out_corr, out_uncorr;
`ifdef SEC_CTRL_ERRCNT_EN
  logic [15:0] cnt_corr, cnt_uncorr;
`endif

  sec_an_decode_ctrl #(.A(A)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_w(req0_w),
    .req1_valid(req1_valid), .req1_w(req1_w),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_n(out_n), .out_id(out_id), .out_corr(out_corr), .out_uncorr(out_uncorr)
`ifdef SEC_CTRL_ERRCNT_EN
    , .cnt_corr(cnt_corr), .cnt_uncorr(cnt_uncorr)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int n;
    int id;
    int corr;
    int uncorr;
    int due;
  } exp_t;

  exp_t sbq[$];
  int   grants[$];
  int   tests = 0, fails = 0, cyc = 0, pref = 0;
  int   cc = 0, cu = 0;
  bit   seen = 0, done = 0;
  exp_t cur;
  logic [14:0] held;
  int   acc_g;
  logic [1:0] acc_exp;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference: decode from the residue rules using plain integer arithmetic.
  function automatic exp_t model(input logic [23:0] w, input int id, input int c);
    exp_t   e;
    longint wl = longint'(w);
    longint r  = wl % AI;
    longint q  = wl / AI;
    longint d  = 0;
    longint p;
    for (int i = 0; i < 24 && d == 0; i++) begin
      p = (longint'(1) << i) % AI;
      if (r == p)           d = longint'(1) << i;
      else if (r == AI - p) d = -(longint'(1) << i);
    end
    e.id = id;
    if (d == 0) begin
      e.n      = int'(q % 4096);
      e.corr   = 0;
      e.uncorr = (r != 0) ? 1 : 0;
      e.due    = c + 1 + 26;
    end else begin
      e.n      = int'((((wl - d) % (longint'(1) << 25) + (longint'(1) << 25)) % (longint'(1) << 25)) / AI % 4096);
      e.corr   = 1;
      e.uncorr = 0;
      e.due    = c + 1 + 51;
    end
    return e;
  endfunction

  function automatic logic [23:0] rand_w();
    longint w;
    int n, k, i;
    do begin
      n = $urandom_range(0, 4095);
      k = $urandom_range(0, 3);
      i = $urandom_range(0, 23);
      case (k)
        0:       w = longint'(n) * AI;
        1:       w = longint'(n) * AI + (longint'(1) << i);
        2:       w = longint'(n) * AI - (longint'(1) << i);
        default: w = longint'(n) * AI + $urandom_range(0, AI - 1);
      endcase
    end while (w < 0 || w >= (longint'(1) << 24));
    return w[23:0];
  endfunction

  // Acceptance monitor: checks arbitration and pushes the expected result.
  always @(negedge clk) begin
    if (rst) begin
      pref = 0;
    end else if (req0_ready || req1_ready) begin
      acc_g   = (req0_valid && req1_valid) ? pref : (req1_valid ? 1 : 0);
      acc_exp = (req0_valid || req1_valid) ? (acc_g == 1 ? 2'b10 : 2'b01) : 2'b00;
      check("grant", {req1_ready, req0_ready}, acc_exp);
      acc_g = req1_ready ? 1 : 0;
      sbq.push_back(model(acc_g == 1 ? req1_w : req0_w, acc_g, cyc));
      grants.push_back(acc_g);
      pref = 1 - acc_g;
    end
  end

  // Output monitor: pops and compares on each new result, then checks it holds.
  always @(negedge clk) begin
    if (rst) begin
      sbq.delete();
      seen = 0;
      cc = 0;
      cu = 0;
    end else if (out_valid) begin
      if (!seen) begin
        if (sbq.size() == 0) begin
          check("spurious_out", out_valid, 0);
        end else begin
          cur = sbq.pop_front();
          check("out_n", out_n, cur.n);
          check("out_id", out_id, cur.id);
          check("out_corr", out_corr, cur.corr);
          check("out_uncorr", out_uncorr, cur.uncorr);
          check("latency_cycle", cyc, cur.due);
          held = {out_n, out_id, out_corr, out_uncorr};
          seen = 1;
        end
      end else begin
        check("out_hold", {out_n, out_id, out_corr, out_uncorr}, held);
      end
      check("ready_during_out", {req1_ready, req0_ready}, 0);
      check("corr_and_uncorr", out_corr && out_uncorr, 0);
      if (out_ready && seen) begin
        if (cur.corr == 1)   cc = (cc < 65535) ? cc + 1 : cc;
        if (cur.uncorr == 1) cu = (cu < 65535) ? cu + 1 : cu;
        seen = 0;
      end
    end
  end

  task automatic send(input int id, input logic [23:0] w);
    int t = 0;
    if (id == 0) begin req0_valid = 1'b1; req0_w = w; end
    else         begin req1_valid = 1'b1; req1_w = w; end
    do begin
      @(negedge clk);
      t++;
    end while (!(id == 0 ? req0_ready : req1_ready) && t < TIMEOUT);
    check("accept_timeout", t < TIMEOUT, 1);
    @(posedge clk);
    #1;
    if (id == 0) req0_valid = 1'b0;
    else         req1_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((sbq.size() != 0 || out_valid) && t < TIMEOUT) begin
      @(negedge clk);
      t++;
    end
    check("drain_timeout", t < TIMEOUT, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    // Reset state, with a requester already offering a codeword.
    req0_valid = 1'b1;
    req0_w     = 24'd16745;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req0_ready", req0_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_n", out_n, 0);
    check("rst_out_flags", {out_id, out_corr, out_uncorr}, 0);
    req0_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;

    // Directed codewords: exact, +8 corrected, -4096 corrected, uncorrectable.
    send(0, 24'd16745); drain();
    send(0, 24'd16753); drain();
    send(0, 24'd12649); drain();
    send(0, 24'd16748); drain();

    // Round-robin with both requesters valid straight out of reset.
    rst = 1'b1;
    grants.delete();
    req0_valid = 1'b1; req0_w = 24'd16745;
    req1_valid = 1'b1; req1_w = 24'd16753;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    fork
      begin for (int k = 0; k < 3; k++) send(0, rand_w()); end
      begin for (int k = 0; k < 3; k++) send(1, rand_w()); end
    join
    drain();
    check("rr_count", grants.size(), 6);
    for (int i = 0; i < grants.size(); i++) check("rr_order", grants[i], i % 2);

    // Backpressure: hold the result for 10 cycles with req1 waiting.
    out_ready = 1'b0;
    send(0, 24'd16753);
    t = 0;
    while (!out_valid && t < TIMEOUT) begin
      @(negedge clk);
      t++;
    end
    check("bp_wait_valid", t < TIMEOUT, 1);
    fork
      send(1, 24'd16745);
    join_none
    repeat (10) @(negedge clk);
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    check("bp_valid_before_hs", out_valid, 1);
    @(negedge clk);
    check("bp_valid_after_hs", out_valid, 0);
    check("bp_idle_grant", req1_ready, 1);
    drain();

    // Randomized traffic with random consumer backpressure.
    done = 0;
    fork
      begin
        fork
          begin
            for (int k = 0; k < 20; k++) begin
              send(0, rand_w());
              repeat ($urandom_range(0, 3)) @(posedge clk);
              #1;
            end
          end
          begin
            for (int k = 0; k < 20; k++) begin
              send(1, rand_w());
              repeat ($urandom_range(0, 3)) @(posedge clk);
              #1;
            end
          end
        join
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset in the middle of a correcting divide: aborted, pointer back to req0.
    send(0, 24'd16753);
    repeat (32) @(posedge clk);
    #1;
    req0_valid = 1'b1; req0_w = 24'd16745;
    req1_valid = 1'b1; req1_w = 24'd16748;
    @(negedge clk);
    check("busy_no_ready", {req1_ready, req0_ready}, 0);
    #2 rst = 1'b1;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_out_n", out_n, 0);
    check("abort_out_flags", {out_id, out_corr, out_uncorr}, 0);
    check("abort_ready", {req1_ready, req0_ready}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_grant", {req1_ready, req0_ready}, 2'b01);
    @(posedge clk);
    #1 req0_valid = 1'b0;
    send(1, 24'd16748);
    drain();

`ifdef SEC_CTRL_ERRCNT_EN
    check("cnt_corr", cnt_corr, cc);
    check("cnt_uncorr", cnt_uncorr, cu);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
